// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// keccak_pkg - shared lane-memory constants, types and FSM states. Rev 1.0
// ============================================================================
package keccak_pkg;

  localparam int LANES  = 25;
  localparam int LANE_W = 64;
  localparam int ADR_W  = 5;

  // Keccak lane bit i ([0:63] numbering, bit 0 MSB-side) is vector bit LANE_W-1-i.
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [ADR_W-1:0]  lane_adr_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic adr_ok(input lane_adr_t adr);
    return adr < lane_adr_t'(LANES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mem_arb.sv
`default_nettype none
// ============================================================================
// lane_mem_arb - engine/host arbitration and sticky error flag update. Rev 1.0
// ============================================================================
module lane_mem_arb
  import keccak_pkg::*;
(
  input  logic             en_i,
  input  logic             mem_r_i,
  input  logic             mem_w_i,
  input  logic [ADR_W-1:0] mem_adr_i,
  input  logic             host_req_i,
  input  logic             host_we_i,
  input  logic [ADR_W-1:0] host_adr_i,
  input  logic [1:0]       err_q_i,
  output logic             eng_wr_o,
  output logic             eng_rd_o,
  output logic             host_gnt_o,
  output logic             host_wr_o,
  output logic             host_rd_o,
  output logic [1:0]       err_d_o
);

  logic w_eng_act;
  logic w_eng_ok;
  logic w_host_ok;
  logic w_conflict;
  logic w_adr_err;

  assign w_eng_act  = en_i & (mem_r_i | mem_w_i);
  assign w_eng_ok   = adr_ok(mem_adr_i);
  assign w_host_ok  = adr_ok(host_adr_i);
  assign w_conflict = en_i & mem_r_i & mem_w_i;

  // A simultaneous read+write keeps the write and drops the read.
  assign eng_wr_o   = en_i & mem_w_i & w_eng_ok;
  assign eng_rd_o   = en_i & mem_r_i & ~mem_w_i;

  // Engine has strict priority: host only gets otherwise idle cycles.
  assign host_gnt_o = en_i & host_req_i & ~mem_r_i & ~mem_w_i;
  assign host_wr_o  = host_gnt_o & host_we_i & w_host_ok;
  assign host_rd_o  = host_gnt_o & ~host_we_i;

  assign w_adr_err  = (w_eng_act & ~w_eng_ok) | (host_gnt_o & ~w_host_ok);
  assign err_d_o    = err_q_i | {w_adr_err, w_conflict};

endmodule
`default_nettype wire

// File: rtl/keccak_lane_mem.sv
`default_nettype none
// ============================================================================
// keccak_lane_mem - 25x64 Keccak lane store, engine + host ports. Rev 1.0
// ============================================================================
module keccak_lane_mem
  import keccak_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADR_W-1:0]  mem_adr,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [LANE_W-1:0] mem_in,
  output logic [LANE_W-1:0] mem_out,
  output logic              mem_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADR_W-1:0]  host_adr,
  input  logic [LANE_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [LANE_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ready,
  output logic [1:0]        err
);

  state_e    state_q;
  lane_adr_t cnt_q;
  logic      ready_q;

  lane_t     lanes_q [LANES];
  lane_t     mem_out_q;
  lane_t     host_rdata_q;
  logic      mem_valid_q;
  logic      host_rvalid_q;
  logic [1:0] err_q;
  logic [1:0] err_d;

  logic w_en;
  logic w_eng_wr;
  logic w_eng_rd;
  logic w_host_gnt;
  logic w_host_wr;
  logic w_host_rd;

  // Masking with reset keeps the combinational grant low in the reset cycle.
  assign w_en = ready_q & ~reset;

  lane_mem_arb u_arb (
    .en_i       (w_en),
    .mem_r_i    (mem_r),
    .mem_w_i    (mem_w),
    .mem_adr_i  (mem_adr),
    .host_req_i (host_req),
    .host_we_i  (host_we),
    .host_adr_i (host_adr),
    .err_q_i    (err_q),
    .eng_wr_o   (w_eng_wr),
    .eng_rd_o   (w_eng_rd),
    .host_gnt_o (w_host_gnt),
    .host_wr_o  (w_host_wr),
    .host_rd_o  (w_host_rd),
    .err_d_o    (err_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_q == READY);
      if (state_q == CLEAR) begin
        if (cnt_q == lane_adr_t'(LANES - 1)) begin
          state_q <= READY;
        end else begin
          cnt_q <= cnt_q + lane_adr_t'(1);
        end
      end
    end
  end

  // Single write port: zero-fill, engine write and host write never coincide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        lanes_q[cnt_q] <= '0;
      end else if (w_eng_wr) begin
        lanes_q[mem_adr] <= mem_in;
      end else if (w_host_wr) begin
        lanes_q[host_adr] <= host_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_out_q     <= '0;
      mem_valid_q   <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      err_q         <= '0;
    end else begin
      mem_valid_q   <= w_eng_rd;
      host_rvalid_q <= w_host_rd;
      err_q         <= err_d;
      if (w_eng_rd) begin
        mem_out_q <= adr_ok(mem_adr) ? lanes_q[mem_adr] : '0;
      end
      if (w_host_rd) begin
        host_rdata_q <= adr_ok(host_adr) ? lanes_q[host_adr] : '0;
      end
    end
  end

  assign mem_out     = mem_out_q;
  assign mem_valid   = mem_valid_q;
  assign host_gnt    = w_host_gnt;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign ready       = ready_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keccak_lane_mem.sv
`default_nettype none
// ============================================================================
// tb_keccak_lane_mem - self-checking bench for keccak_lane_mem. Rev 1.0
// ============================================================================
module tb_keccak_lane_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  mem_adr;
  logic        mem_r;
  logic        mem_w;
  logic [63:0] mem_in;
  logic [63:0] mem_out;
  logic        mem_valid;
  logic        host_req;
  logic        host_we;
  logic [4:0]  host_adr;
  logic [63:0] host_wdata;
  logic        host_gnt;
  logic [63:0] host_rdata;
  logic        host_rvalid;
  logic        ready;
  logic [1:0]  err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] m_lane [25];
  logic [63:0] m_out;
  logic [63:0] m_rdata;
  logic [1:0]  m_err;

  typedef struct {
    logic        host;
    logic        we;
    logic [4:0]  adr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  keccak_lane_mem dut (
    .clock       (clock),
    .reset       (reset),
    .mem_adr     (mem_adr),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .mem_valid   (mem_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_adr    (host_adr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .ready       (ready),
    .err         (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic idle_inputs();
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_adr    = '0;
    mem_in     = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_adr   = '0;
    host_wdata = '0;
  endtask

  // Samples the combinational grant before the edge, returns 1 time unit after it.
  task automatic tick(output logic g);
    #2;
    g = host_gnt;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    logic g;
    for (int k = 0; k < 40 && ready !== 1'b1; k++) tick(g);
    chk(name, ready, 1'b1);
  endtask

  function automatic logic bad(input logic [4:0] a);
    return a > 5'd24;
  endfunction

  initial begin
    logic g;
    logic [4:0]  a, ha;
    logic [63:0] d, hd;
    logic        e_r, e_w, h_req, h_we, exp_gnt, exp_mv, exp_hv;
    int          r;

    // Reset cycle with a pending host read: nothing may be granted during clear.
    idle_inputs();
    reset    = 1'b1;
    host_req = 1'b1;
    tick(g);
    chk("rst_gnt", g, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_out", mem_out, 64'h0);
    chk("rst_host_rvalid", host_rvalid, 1'b0);
    chk("rst_host_rdata", host_rdata, 64'h0);
    chk("rst_err", err, 2'b00);
    reset = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick(g);
      chk("clear_ready", ready, (k == 26) ? 1'b1 : 1'b0);
      chk("clear_gnt", g, 1'b0);
      chk("clear_rvalid", host_rvalid, 1'b0);
    end
    idle_inputs();

    vt[0]  = '{host: 1'b1, we: 1'b0, adr: 5'd0,  data: 64'h0, exp: 64'h0};
    vt[1]  = '{host: 1'b1, we: 1'b0, adr: 5'd12, data: 64'h0, exp: 64'h0};
    vt[2]  = '{host: 1'b1, we: 1'b0, adr: 5'd24, data: 64'h0, exp: 64'h0};
    vt[3]  = '{host: 1'b1, we: 1'b1, adr: 5'd7,  data: 64'hDEADBEEF_01234567, exp: 64'h0};
    vt[4]  = '{host: 1'b0, we: 1'b0, adr: 5'd7,  data: 64'h0, exp: 64'hDEADBEEF_01234567};
    vt[5]  = '{host: 1'b0, we: 1'b1, adr: 5'd24, data: 64'hCAFEF00D_00000001, exp: 64'h0};
    vt[6]  = '{host: 1'b1, we: 1'b0, adr: 5'd24, data: 64'h0, exp: 64'hCAFEF00D_00000001};
    vt[7]  = '{host: 1'b0, we: 1'b1, adr: 5'd0,  data: 64'h1111, exp: 64'h0};
    vt[8]  = '{host: 1'b0, we: 1'b0, adr: 5'd0,  data: 64'h0, exp: 64'h1111};
    vt[9]  = '{host: 1'b1, we: 1'b1, adr: 5'd12, data: 64'hA5A5A5A5_5A5A5A5A, exp: 64'h0};
    vt[10] = '{host: 1'b1, we: 1'b0, adr: 5'd12, data: 64'h0, exp: 64'hA5A5A5A5_5A5A5A5A};
    vt[11] = '{host: 1'b0, we: 1'b0, adr: 5'd12, data: 64'h0, exp: 64'hA5A5A5A5_5A5A5A5A};

    for (int i = 0; i < NV; i++) begin
      idle_inputs();
      if (vt[i].host) begin
        host_req   = 1'b1;
        host_we    = vt[i].we;
        host_adr   = vt[i].adr;
        host_wdata = vt[i].data;
      end else begin
        mem_r   = ~vt[i].we;
        mem_w   = vt[i].we;
        mem_adr = vt[i].adr;
        mem_in  = vt[i].data;
      end
      tick(g);
      if (vt[i].host) chk("tbl_gnt", g, 1'b1);
      if (!vt[i].we) begin
        if (vt[i].host) begin
          chk("tbl_host_rvalid", host_rvalid, 1'b1);
          chk("tbl_host_rdata", host_rdata, vt[i].exp);
        end else begin
          chk("tbl_mem_valid", mem_valid, 1'b1);
          chk("tbl_mem_out", mem_out, vt[i].exp);
        end
      end
    end
    chk("tbl_err", err, 2'b00);

    // Host preload lane i = i, then stream engine reads 0..24.
    for (int i = 0; i < 25; i++) begin
      idle_inputs();
      host_req = 1'b1; host_we = 1'b1; host_adr = 5'(i); host_wdata = 64'(i);
      tick(g);
      chk("pre_gnt", g, 1'b1);
    end
    for (int i = 0; i < 25; i++) begin
      idle_inputs();
      mem_r = 1'b1; mem_adr = 5'(i);
      tick(g);
      chk("stream_valid", mem_valid, 1'b1);
      chk("stream_out", mem_out, 64'(i));
    end

    // Host starves while the engine writes for 4 cycles.
    idle_inputs();
    host_req = 1'b1; host_we = 1'b1; host_adr = 5'd10; host_wdata = 64'hAB;
    for (int i = 1; i <= 4; i++) begin
      mem_w = 1'b1; mem_adr = 5'(i); mem_in = 64'h100 + 64'(i);
      tick(g);
      chk("starve_gnt", g, 1'b0);
    end
    mem_w = 1'b0;
    tick(g);
    chk("starve_release_gnt", g, 1'b1);
    idle_inputs();
    host_req = 1'b1; host_adr = 5'd10;
    tick(g);
    chk("starve_host_rdata", host_rdata, 64'hAB);
    idle_inputs();
    mem_r = 1'b1; mem_adr = 5'd2;
    tick(g);
    chk("starve_eng_out", mem_out, 64'h102);

    // Read+write conflict, then an out-of-range read.
    idle_inputs();
    mem_r = 1'b1; mem_w = 1'b1; mem_adr = 5'd3; mem_in = 64'h5;
    tick(g);
    chk("conf_valid", mem_valid, 1'b0);
    chk("conf_err", err, 2'b01);
    idle_inputs();
    mem_r = 1'b1; mem_adr = 5'd30;
    tick(g);
    chk("oob_valid", mem_valid, 1'b1);
    chk("oob_out", mem_out, 64'h0);
    chk("oob_err", err, 2'b11);
    idle_inputs();
    host_req = 1'b1; host_adr = 5'd3;
    tick(g);
    chk("conf_lane3", host_rdata, 64'h5);

    // Reset lands on an engine read: no pulse, full re-clear.
    idle_inputs();
    mem_r = 1'b1; mem_adr = 5'd7; reset = 1'b1;
    tick(g);
    chk("mid_rst_valid", mem_valid, 1'b0);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_err", err, 2'b00);
    reset = 1'b0;
    idle_inputs();
    wait_ready("mid_rst_ready_timeout");
    for (int i = 0; i < 25; i++) begin
      idle_inputs();
      mem_r = 1'b1; mem_adr = 5'(i);
      tick(g);
      chk("mid_rst_lane_zero", mem_out, 64'h0);
    end

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 25; i++) m_lane[i] = 64'h0;
    m_out = 64'h0; m_rdata = 64'h0; m_err = 2'b00;
    for (int n = 0; n < 400; n++) begin
      r     = $urandom_range(0, 15);
      e_r   = (r < 5) || (r == 10);
      e_w   = (r >= 5 && r <= 10);
      a     = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
      ha    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
      d     = {$urandom, $urandom};
      hd    = {$urandom, $urandom};
      h_req = 1'($urandom_range(0, 1));
      h_we  = 1'($urandom_range(0, 1));

      exp_gnt = h_req && !e_r && !e_w;
      exp_mv  = 1'b0;
      exp_hv  = 1'b0;
      if (e_r && e_w) begin
        m_err[0] = 1'b1;
        if (bad(a)) m_err[1] = 1'b1; else m_lane[a] = d;
      end else if (e_r) begin
        exp_mv = 1'b1;
        if (bad(a)) begin m_err[1] = 1'b1; m_out = 64'h0; end else m_out = m_lane[a];
      end else if (e_w) begin
        if (bad(a)) m_err[1] = 1'b1; else m_lane[a] = d;
      end else if (exp_gnt) begin
        if (h_we) begin
          if (bad(ha)) m_err[1] = 1'b1; else m_lane[ha] = hd;
        end else begin
          exp_hv = 1'b1;
          if (bad(ha)) begin m_err[1] = 1'b1; m_rdata = 64'h0; end else m_rdata = m_lane[ha];
        end
      end

      mem_r = e_r; mem_w = e_w; mem_adr = a; mem_in = d;
      host_req = h_req; host_we = h_we; host_adr = ha; host_wdata = hd;
      tick(g);
      chk("rnd_gnt", g, exp_gnt);
      chk("rnd_mem_valid", mem_valid, exp_mv);
      chk("rnd_mem_out", mem_out, m_out);
      chk("rnd_host_rvalid", host_rvalid, exp_hv);
      chk("rnd_host_rdata", host_rdata, m_rdata);
      chk("rnd_err", err, m_err);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
